core_dispatcher: RTL and testbench

Launch-and-join controller for the multi-core matrix multiplier. It sits directly upstream of the processing cores. It drives each core's `i_start`, confirms every selected core has raised `o_busy`, waits for all of them to finish, then reports completion, run length in cycles, and any core that failed to start. The host sees a single go/done handshake instead of N start/busy pairs.

---
 rtl/core_dispatcher_pkg.sv | 17 +
 rtl/core_dispatcher_sat_counter.sv | 33 +++
 rtl/core_dispatcher.sv | 128 ++++++++++++
 tb/tb_core_dispatcher.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/core_dispatcher_pkg.sv
// Shared definitions for the core dispatcher: state encodings and default
// parameter values, also used when sizing the surrounding core array.
package core_dispatcher_pkg;

  localparam int DEF_NUM_CORES = 4;
  localparam int DEF_TIMEOUT   = 16;
  localparam int DEF_CYC_W     = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_RUN    = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERR    = 3'd4
  } state_e;

endpackage

// File: rtl/core_dispatcher_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign q = count_q;

endmodule

// File: rtl/core_dispatcher.sv
// Launch-and-join controller: starts a set of cores, confirms each went busy,
// waits for all to finish and reports run length or cores that never started.
//
// state  | meaning
// IDLE   | ready for a launch request
// LAUNCH | driving start to cores not yet seen busy, timeout running
// RUN    | all selected cores busy, waiting for them to drop busy
// DONE   | one-cycle completion pulse
// ERR    | some core never went busy; held until cleared
module core_dispatcher
  import core_dispatcher_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int CYC_W     = DEF_CYC_W
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_go,
  input  logic [NUM_CORES-1:0] i_core_mask,
  input  logic [NUM_CORES-1:0] i_busy,
  input  logic                 i_clear,
  output logic [NUM_CORES-1:0] o_start,
  output logic                 o_ready,
  output logic                 o_done,
  output logic                 o_err,
  output logic [NUM_CORES-1:0] o_err_mask,
  output logic [CYC_W-1:0]     o_cycles
);

  localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_e state_q, state_d;
  logic [NUM_CORES-1:0] act_mask_q, act_mask_d;
  logic [NUM_CORES-1:0] seen_q, seen_d;
  logic [NUM_CORES-1:0] err_mask_q, err_mask_d;
  logic                 cnt_clr;
  logic [TMO_W-1:0]     tmo_q;
  logic [CYC_W-1:0]     cyc_q;

  always_comb begin
    state_d    = state_q;
    act_mask_d = act_mask_q;
    seen_d     = seen_q;
    err_mask_d = err_mask_q;
    cnt_clr    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_go) begin
          cnt_clr = 1'b1;
          if (|i_core_mask) begin
            act_mask_d = i_core_mask;
            seen_d     = '0;
            state_d    = ST_LAUNCH;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_LAUNCH: begin
        seen_d = seen_q | (act_mask_q & i_busy);
        // All cores confirmed wins over a timeout landing on the same edge.
        if (seen_d == act_mask_q) begin
          state_d = ST_RUN;
        end else if (tmo_q == TMO_LAST) begin
          err_mask_d = act_mask_q & ~seen_d;
          state_d    = ST_ERR;
        end
      end
      ST_RUN: begin
        if ((i_busy & act_mask_q) == '0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        if (i_clear) begin
          err_mask_d = '0;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      act_mask_q <= '0;
      seen_q     <= '0;
      err_mask_q <= '0;
    end else begin
      state_q    <= state_d;
      act_mask_q <= act_mask_d;
      seen_q     <= seen_d;
      err_mask_q <= err_mask_d;
    end
  end

  sat_counter #(.W(TMO_W)) u_tmo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .clr     (cnt_clr),
    .en      (state_q == ST_LAUNCH),
    .q       (tmo_q)
  );

  sat_counter #(.W(CYC_W)) u_cyc (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .clr     (cnt_clr),
    .en      ((state_q == ST_LAUNCH) || (state_q == ST_RUN)),
    .q       (cyc_q)
  );

  assign o_start    = (state_q == ST_LAUNCH) ? (act_mask_q & ~seen_q) : '0;
  assign o_ready    = (state_q == ST_IDLE);
  assign o_done     = (state_q == ST_DONE);
  assign o_err      = (state_q == ST_ERR);
  assign o_err_mask = err_mask_q;
  assign o_cycles   = cyc_q;

endmodule

// File: tb/tb_core_dispatcher.sv
// Directed bench for core_dispatcher: a default instance plus a CYC_W=4
// instance for the saturation case, inputs driven and outputs sampled at negedge.
module tb_core_dispatcher;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       go = 1'b0, clear = 1'b0;
  logic [3:0] mask = '0, busy = '0;
  logic [3:0] start, err_mask;
  logic       ready, done, err;
  logic [31:0] cycles;

  logic       go2 = 1'b0;
  logic [3:0] mask2 = '0, busy2 = '0;
  logic [3:0] start2, err_mask2;
  logic       ready2, done2, err2;
  logic [3:0] cycles2;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  core_dispatcher #(.NUM_CORES(4), .TIMEOUT(16), .CYC_W(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_go(go), .i_core_mask(mask),
    .i_busy(busy), .i_clear(clear), .o_start(start), .o_ready(ready),
    .o_done(done), .o_err(err), .o_err_mask(err_mask), .o_cycles(cycles)
  );

  core_dispatcher #(.NUM_CORES(4), .TIMEOUT(16), .CYC_W(4)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_go(go2), .i_core_mask(mask2),
    .i_busy(busy2), .i_clear(1'b0), .o_start(start2), .o_ready(ready2),
    .o_done(done2), .o_err(err2), .o_err_mask(err_mask2), .o_cycles(cycles2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    // Reset state
    tick(2);
    check("rst_start", 32'(start), 32'h0);
    check("rst_ready", 32'(ready), 32'h1);
    check("rst_done", 32'(done), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_err_mask", 32'(err_mask), 32'h0);
    check("rst_cycles", cycles, 32'h0);
    check("rst_cycles_sat", 32'(cycles2), 32'h0);
    rst_n = 1'b1;
    tick(1);

    // Happy path, mask 1111, busy one cycle after start, held 20 cycles
    go = 1'b1; mask = 4'b1111;
    tick(1);
    check("hp_start_c1", 32'(start), 32'hF);
    check("hp_ready_low", 32'(ready), 32'h0);
    go = 1'b0;
    tick(1);
    check("hp_start_c2", 32'(start), 32'hF);
    busy = 4'b1111;
    tick(1);
    check("hp_start_off", 32'(start), 32'h0);
    tick(19);
    check("hp_no_early_done", 32'(done), 32'h0);
    busy = 4'b0000;
    tick(1);
    check("hp_done", 32'(done), 32'h1);
    check("hp_cycles", cycles, 32'd22);
    tick(1);
    check("hp_done_once", 32'(done), 32'h0);
    check("hp_ready_back", 32'(ready), 32'h1);
    check("hp_cycles_held", cycles, 32'd22);

    // Staggered starts, mask 0101: core0 busy after 1 cycle, core2 after 5
    go = 1'b1; mask = 4'b0101;
    tick(1);
    check("st_start_c1", 32'(start), 32'h5);
    go = 1'b0;
    tick(1);
    check("st_start_c2", 32'(start), 32'h5);
    busy = 4'b0001;
    tick(1);
    check("st_start0_drop", 32'(start), 32'h4);
    tick(3);
    check("st_start2_c6", 32'(start), 32'h4);
    busy = 4'b0101;
    tick(1);
    check("st_start2_drop", 32'(start), 32'h0);
    busy = 4'b0000;
    tick(1);
    check("st_done", 32'(done), 32'h1);
    check("st_cycles", cycles, 32'd7);
    tick(1);

    // Empty mask: DONE immediately with zero cycles
    go = 1'b1; mask = 4'b0000;
    tick(1);
    check("em_done", 32'(done), 32'h1);
    check("em_cycles", cycles, 32'h0);
    check("em_start", 32'(start), 32'h0);
    go = 1'b0;
    tick(1);
    check("em_ready", 32'(ready), 32'h1);

    // Ignored inputs in RUN: i_go pulses and unmasked busy bits
    go = 1'b1; mask = 4'b0001;
    tick(1);
    check("ig_start", 32'(start), 32'h1);
    go = 1'b0; busy = 4'b0001;
    tick(1);
    check("ig_run_start", 32'(start), 32'h0);
    go = 1'b1; busy = 4'b1111;
    tick(1);
    check("ig_no_done", 32'(done), 32'h0);
    check("ig_no_start", 32'(start), 32'h0);
    check("ig_not_ready", 32'(ready), 32'h0);
    busy = 4'b1110;
    tick(1);
    check("ig_done", 32'(done), 32'h1);
    check("ig_cycles", cycles, 32'd3);
    go = 1'b0; busy = 4'b0000;
    tick(1);
    check("ig_ready", 32'(ready), 32'h1);

    // Timeout, mask 0011, core1 never goes busy
    go = 1'b1; mask = 4'b0011;
    tick(1);
    check("to_start", 32'(start), 32'h3);
    go = 1'b0;
    tick(1);
    busy = 4'b0001;
    tick(1);
    check("to_start1_only", 32'(start), 32'h2);
    tick(13);
    check("to_no_err_c15", 32'(err), 32'h0);
    tick(1);
    check("to_err", 32'(err), 32'h1);
    check("to_err_mask", 32'(err_mask), 32'h2);
    check("to_start_off", 32'(start), 32'h0);
    go = 1'b1;
    tick(3);
    check("to_err_hold", 32'(err), 32'h1);
    check("to_not_ready", 32'(ready), 32'h0);
    go = 1'b0; busy = 4'b0000; clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("to_cleared", 32'(err), 32'h0);
    check("to_ready", 32'(ready), 32'h1);
    check("to_mask_clr", 32'(err_mask), 32'h0);

    // Reset mid-RUN
    go = 1'b1; mask = 4'b0001;
    tick(1);
    go = 1'b0; busy = 4'b0001;
    tick(2);
    check("rr_in_run", 32'(ready), 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("rr_ready_async", 32'(ready), 32'h1);
    check("rr_cycles_async", cycles, 32'h0);
    check("rr_start_async", 32'(start), 32'h0);
    tick(1);
    rst_n = 1'b1; busy = 4'b0000;
    tick(1);
    go = 1'b1; mask = 4'b0010;
    tick(1);
    check("rr_relaunch", 32'(start), 32'h2);
    go = 1'b0;
    tick(1);
    busy = 4'b0010;
    tick(1);
    busy = 4'b0000;
    tick(1);
    check("rr_done", 32'(done), 32'h1);
    check("rr_cycles", cycles, 32'd3);

    // Saturation on the CYC_W=4 instance, busy held 30 cycles
    go2 = 1'b1; mask2 = 4'b0001;
    tick(1);
    check("sa_start", 32'(start2), 32'h1);
    go2 = 1'b0; busy2 = 4'b0001;
    tick(14);
    check("sa_cycles_mid", 32'(cycles2), 32'hE);
    tick(16);
    busy2 = 4'b0000;
    tick(1);
    check("sa_done", 32'(done2), 32'h1);
    check("sa_cycles", 32'(cycles2), 32'hF);
    tick(1);
    check("sa_ready", 32'(ready2), 32'h1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
